prime_pair_gen: RTL and testbench

Upstream stage of the RSA pipeline: on `start`, searches pseudo-random odd candidates for two distinct primes `p` and `q` of `WIDTH` bits with MSB set. It presents them on `p`/`q` and pulses `done`, which drives the key generator's start input directly. Candidates come from a Galois LFSR. Primality is checked by trial division with odd divisors, using a sequential restoring-remainder sub-unit.

---
 rtl/prime_pair_gen_pkg.sv | 18 +
 rtl/prime_pair_gen_mod_unit.sv | 63 ++++++
 rtl/prime_pair_gen.sv | 158 +++++++++++++++
 tb/tb_prime_pair_gen.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/prime_pair_gen_pkg.sv
// Shared constants for the prime pair generator: FSM encodings and
// the LFSR/divisor start values.
package prime_pair_gen_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_LOAD      = 3'd1;
  localparam state_t ST_BOUND     = 3'd2;
  localparam state_t ST_DIV_START = 3'd3;
  localparam state_t ST_DIV_WAIT  = 3'd4;
  localparam state_t ST_VERDICT   = 3'd5;
  localparam state_t ST_FINISH    = 3'd6;

  localparam int LFSR_RESET = 1;
  localparam int DIV_INIT   = 3;

endpackage

// File: rtl/prime_pair_gen_mod_unit.sv
// Sequential restoring remainder: one dividend bit per cycle, MSB first.
// The first bit is consumed on the go edge so rem_valid lands WIDTH cycles after go.
module mod_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH:0]   divisor,
  output logic [WIDTH:0]   rem,
  output logic             rem_valid
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH:0]   rem_reg;
  logic [WIDTH-1:0] shift_reg;
  logic [CW-1:0]    cnt_reg;
  logic             valid_reg;

  logic [WIDTH+1:0] trial;
  logic [WIDTH+1:0] reduced;

  // Partial remainder shifted left with the next dividend bit, then conditionally reduced.
  always_comb begin
    if (go) begin
      trial = {{(WIDTH+1){1'b0}}, dividend[WIDTH-1]};
    end else begin
      trial = {rem_reg, shift_reg[WIDTH-1]};
    end
    if (trial >= {1'b0, divisor}) begin
      reduced = trial - {1'b0, divisor};
    end else begin
      reduced = trial;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_reg   <= '0;
      shift_reg <= '0;
      cnt_reg   <= '0;
      valid_reg <= 1'b0;
    end else if (go) begin
      rem_reg   <= reduced[WIDTH:0];
      shift_reg <= {dividend[WIDTH-2:0], 1'b0};
      cnt_reg   <= CW'(WIDTH - 1);
      valid_reg <= 1'b0;
    end else if (cnt_reg != '0) begin
      rem_reg   <= reduced[WIDTH:0];
      shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
      cnt_reg   <= cnt_reg - 1'b1;
      valid_reg <= (cnt_reg == CW'(1));
    end else begin
      valid_reg <= 1'b0;
    end
  end

  assign rem       = rem_reg;
  assign rem_valid = valid_reg;

endmodule

// File: rtl/prime_pair_gen.sv
// Searches LFSR-generated odd candidates (MSB forced) for two distinct primes
// by trial division, then presents them on p/q with a one-cycle done pulse.
module prime_pair_gen
  import prime_pair_gen_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] TAPS      = 8'hB8,
  parameter int               MAX_TRIES = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             fail
);

  localparam int               TW         = $clog2(MAX_TRIES + 1);
  localparam logic [TW-1:0]    TRIES_LAST = TW'(MAX_TRIES - 1);
  localparam logic [WIDTH-1:0] CAND_FORCE = (WIDTH'(1) << (WIDTH - 1)) | WIDTH'(1);

  state_t           state_reg;
  logic [WIDTH-1:0] lfsr_reg;
  logic [WIDTH:0]   d_reg;
  logic [TW-1:0]    tries_reg;
  logic [WIDTH-1:0] p_lat_reg;
  logic             have_p_reg;
  logic             is_prime_reg;
  logic [WIDTH-1:0] p_reg;
  logic [WIDTH-1:0] q_reg;
  logic             done_reg;
  logic             fail_reg;

  logic [WIDTH-1:0]   cand;
  logic [WIDTH-1:0]   lfsr_adv;
  logic [2*WIDTH+1:0] d_sq;
  logic               bound_hit;
  logic               accept_p;
  logic               accept_q;
  logic               last_try;
  logic               div_go;
  logic [WIDTH:0]     rem;
  logic               rem_valid;

  assign cand      = lfsr_reg | CAND_FORCE;
  assign lfsr_adv  = (lfsr_reg >> 1) ^ (lfsr_reg[0] ? TAPS : '0);
  assign d_sq      = {{(WIDTH+1){1'b0}}, d_reg} * {{(WIDTH+1){1'b0}}, d_reg};
  assign bound_hit = d_sq > {{(WIDTH+2){1'b0}}, cand};
  // A prime equal to the already-latched p does not count as the second prime.
  assign accept_p  = is_prime_reg && !have_p_reg;
  assign accept_q  = is_prime_reg && have_p_reg && (cand != p_lat_reg);
  assign last_try  = (tries_reg == TRIES_LAST);
  assign div_go    = (state_reg == ST_DIV_START);

  mod_unit #(
    .WIDTH(WIDTH)
  ) u_mod (
    .clk      (clk),
    .rst      (rst),
    .go       (div_go),
    .dividend (cand),
    .divisor  (d_reg),
    .rem      (rem),
    .rem_valid(rem_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      lfsr_reg     <= WIDTH'(LFSR_RESET);
      d_reg        <= (WIDTH+1)'(DIV_INIT);
      tries_reg    <= '0;
      p_lat_reg    <= '0;
      have_p_reg   <= 1'b0;
      is_prime_reg <= 1'b0;
      p_reg        <= '0;
      q_reg        <= '0;
      done_reg     <= 1'b0;
      fail_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      fail_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_reg <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          lfsr_reg   <= (seed == '0) ? WIDTH'(LFSR_RESET) : seed;
          d_reg      <= (WIDTH+1)'(DIV_INIT);
          tries_reg  <= '0;
          have_p_reg <= 1'b0;
          state_reg  <= ST_BOUND;
        end
        ST_BOUND: begin
          if (bound_hit) begin
            is_prime_reg <= 1'b1;
            state_reg    <= ST_VERDICT;
          end else begin
            state_reg <= ST_DIV_START;
          end
        end
        ST_DIV_START: begin
          state_reg <= ST_DIV_WAIT;
        end
        ST_DIV_WAIT: begin
          if (rem_valid) begin
            if (rem == '0) begin
              is_prime_reg <= 1'b0;
              state_reg    <= ST_VERDICT;
            end else begin
              d_reg     <= d_reg + (WIDTH+1)'(2);
              state_reg <= ST_BOUND;
            end
          end
        end
        ST_VERDICT: begin
          lfsr_reg  <= lfsr_adv;
          tries_reg <= tries_reg + 1'b1;
          d_reg     <= (WIDTH+1)'(DIV_INIT);
          if (accept_p) begin
            p_lat_reg  <= cand;
            have_p_reg <= 1'b1;
          end
          // Outputs update on the edge into FINISH so they are valid alongside done.
          if (accept_q) begin
            p_reg     <= p_lat_reg;
            q_reg     <= cand;
            done_reg  <= 1'b1;
            state_reg <= ST_FINISH;
          end else if (last_try) begin
            fail_reg  <= 1'b1;
            state_reg <= ST_FINISH;
          end else begin
            state_reg <= ST_BOUND;
          end
        end
        ST_FINISH: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign p    = p_reg;
  assign q    = q_reg;
  assign busy = (state_reg != ST_IDLE);
  assign done = done_reg;
  assign fail = fail_reg;

endmodule

// File: tb/tb_prime_pair_gen.sv
// Scoreboard bench for prime_pair_gen: stimulus pushes expected results,
// per-DUT monitors pop and compare on every done/fail pulse.
module tb_prime_pair_gen;

  typedef struct packed {
    logic       is_done;
    logic [7:0] p;
    logic [7:0] q;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start1 = 1'b0, start2 = 1'b0;
  logic [7:0] seed1 = '0, seed2 = '0;
  logic [7:0] p1, q1, p2, q2;
  logic       busy1, done1, fail1, busy2, done2, fail2;

  int checks = 0;
  int errors = 0;
  exp_t exp_q1[$];
  exp_t exp_q2[$];
  logic [7:0] last_p = '0, last_q = '0;

  always #5 clk = ~clk;

  prime_pair_gen #(.WIDTH(8), .TAPS(8'hB8), .MAX_TRIES(64)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .seed(seed1),
    .p(p1), .q(q1), .busy(busy1), .done(done1), .fail(fail1)
  );

  prime_pair_gen #(.WIDTH(8), .TAPS(8'hB8), .MAX_TRIES(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .seed(seed2),
    .p(p2), .q(q2), .busy(busy2), .done(done2), .fail(fail2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic bit ref_prime(input int n);
    if (n < 2) return 1'b0;
    if (n % 2 == 0) return (n == 2);
    for (int d = 3; d * d <= n; d += 2)
      if (n % d == 0) return 1'b0;
    return 1'b1;
  endfunction

  // Reference search for WIDTH=8, TAPS=B8, MAX_TRIES=64.
  function automatic exp_t ref_search(input logic [7:0] s);
    logic [7:0] lfsr;
    logic [7:0] cand;
    bit         have_p;
    exp_t       e;
    lfsr   = (s == 8'd0) ? 8'd1 : s;
    have_p = 1'b0;
    e      = '{is_done: 1'b0, p: last_p, q: last_q};
    for (int t = 0; t < 64; t++) begin
      cand = lfsr | 8'h81;
      if (ref_prime(int'(cand))) begin
        if (!have_p) begin
          e.p = cand;
          have_p = 1'b1;
        end else if (cand != e.p) begin
          e.q = cand;
          e.is_done = 1'b1;
          return e;
        end
      end
      lfsr = (lfsr >> 1) ^ (lfsr[0] ? 8'hB8 : 8'h00);
    end
    e.p = last_p;
    e.q = last_q;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (done1 || fail1) begin
      $display("txn dut1 done=%0b fail=%0b p=%0d q=%0d", done1, fail1, p1, q1);
      if (exp_q1.size() == 0) begin
        chk("dut1_unexpected_output", 1, 0);
      end else begin
        e = exp_q1.pop_front();
        chk("dut1_done", done1, e.is_done);
        chk("dut1_fail", fail1, !e.is_done);
        chk("dut1_p", p1, e.p);
        chk("dut1_q", q1, e.q);
        chk("dut1_busy_at_pulse", busy1, 1);
        if (done1) begin
          chk("dut1_p_prime", ref_prime(int'(p1)), 1);
          chk("dut1_q_prime", ref_prime(int'(q1)), 1);
          chk("dut1_msb", p1[7] & q1[7], 1);
          chk("dut1_p_ne_q", (p1 != q1), 1);
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (done2 || fail2) begin
      $display("txn dut2 done=%0b fail=%0b p=%0d q=%0d", done2, fail2, p2, q2);
      if (exp_q2.size() == 0) begin
        chk("dut2_unexpected_output", 1, 0);
      end else begin
        e = exp_q2.pop_front();
        chk("dut2_done", done2, e.is_done);
        chk("dut2_fail", fail2, !e.is_done);
        chk("dut2_p", p2, e.p);
        chk("dut2_q", q2, e.q);
      end
    end
  end

  task automatic wait_idle1();
    int n = 0;
    while (busy1 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("dut1_idle_timeout", busy1, 0);
    chk("dut1_done_low_after", done1, 0);
  endtask

  task automatic launch1(input logic [7:0] s);
    @(negedge clk);
    seed1  = s;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk("dut1_busy_rise", busy1, 1);
  endtask

  task automatic run1(input logic [7:0] s, input exp_t e);
    exp_q1.push_back(e);
    if (e.is_done) begin
      last_p = e.p;
      last_q = e.q;
    end
    launch1(s);
    wait_idle1();
  endtask

  initial begin
    exp_t e;
    int   n;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_p", p1, 0);
    chk("rst_q", q1, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_fail", fail1, 0);

    // Seed 0: 129,185,221,175 composite, then 151 and 179.
    run1(8'h00, '{is_done: 1'b1, p: 8'd151, q: 8'd179});
    run1(8'h16, '{is_done: 1'b1, p: 8'd151, q: 8'd139});

    // Second start while busy must be ignored.
    exp_q1.push_back('{is_done: 1'b1, p: 8'd151, q: 8'd179});
    launch1(8'h00);
    repeat (20) @(negedge clk);
    chk("dut1_busy_mid_run", busy1, 1);
    seed1  = 8'h16;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    wait_idle1();
    repeat (5) @(negedge clk);
    chk("dut1_no_relaunch", busy1, 0);

    // Reset during the first division of a run.
    launch1(8'h00);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_p", p1, 0);
    chk("midrst_q", q1, 0);
    chk("midrst_busy", busy1, 0);
    chk("midrst_done", done1, 0);
    chk("midrst_fail", fail1, 0);
    last_p = '0;
    last_q = '0;
    run1(8'h00, '{is_done: 1'b1, p: 8'd151, q: 8'd179});

    // Two-try budget with seed 0: two composites then fail, outputs untouched.
    exp_q2.push_back('{is_done: 1'b0, p: 8'd0, q: 8'd0});
    @(negedge clk);
    seed2  = 8'h00;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    chk("dut2_busy_rise", busy2, 1);
    n = 0;
    while (busy2 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("dut2_idle_timeout", busy2, 0);

    for (int i = 0; i < 6; i++) begin
      logic [7:0] s;
      s = 8'($urandom_range(0, 255));
      e = ref_search(s);
      run1(s, e);
    end

    repeat (3) @(negedge clk);
    chk("dut1_missing_outputs", exp_q1.size(), 0);
    chk("dut2_missing_outputs", exp_q2.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
